// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer (TC0/TC1 windows):
// register offsets, FSM state codes, mode codes and the CTRL field layout.
package timer_counter_pkg;

    // Word offsets within a timer window, decoded from Addr[3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_UNUSED = 2'd3;

    localparam logic [1:0] TC_IDLE = 2'd0;
    localparam logic [1:0] TC_LOAD = 2'd1;
    localparam logic [1:0] TC_CNT  = 2'd2;
    localparam logic [1:0] TC_INT  = 2'd3;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;

    // Byte address windows the bridge decodes for the two instances
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_LAST = 32'h0000_7F0F;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_LAST = 32'h0000_7F1F;

    typedef logic [1:0] tc_state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       enable;
    } tc_ctrl_t;

    function automatic logic tc_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of one timer instance: word address, write strobe,
// store data, combinational read data and the level interrupt.
interface timer_counter_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Countdown timer: CTRL/PRESET/COUNT register file plus the IDLE/LOAD/CNT/INT FSM.
// Define TIMER_STATE_READ_EN to expose FSM state in CTRL[5:4] and irq_flag in CTRL[6].
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'd0,
    parameter int unsigned CTRL_WBITS = 4
) (
    input logic            clk,
    input logic            reset,
    timer_counter_if.slave bus
);

    logic [CTRL_WBITS-1:0] ctrl_q, ctrl_d;
    logic [31:0]           preset_q, preset_d;
    logic [31:0]           count_q, count_d;
    tc_state_t             state_q, state_d;
    logic                  irq_flag_q, irq_flag_d;

    tc_ctrl_t    ctrl_f;
    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_view;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr_bits;

    assign ctrl_f           = tc_ctrl_t'(ctrl_q[3:0]);
    assign ctrl_wr          = bus.WE && (bus.Addr[3:2] == TC_CTRL);
    assign preset_wr        = bus.WE && (bus.Addr[3:2] == TC_PRESET);
    assign unused_addr_bits = ^bus.Addr[31:4];

    // Zero-extend the writable CTRL bits onto the 32-bit read bus
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ctrl_rd
            if (gi < CTRL_WBITS) begin : g_stored
                assign ctrl_rd[gi] = ctrl_q[gi];
            end else begin : g_zero
                assign ctrl_rd[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;

        case (state_q)
            TC_IDLE: begin
                if (ctrl_f.enable) state_d = TC_LOAD;
            end
            TC_LOAD: begin
                count_d = preset_q;
                state_d = TC_CNT;
            end
            TC_CNT: begin
                if (!ctrl_f.enable) begin
                    state_d = TC_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Also covers PRESET=0: terminate instead of wrapping
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = TC_INT;
                end
            end
            TC_INT: begin
                state_d = TC_IDLE;
                if (ctrl_f.mode == TC_MODE_RELOAD) irq_flag_d = 1'b0;
                else ctrl_d[0] = 1'b0;
            end
            default: state_d = TC_IDLE;
        endcase

        // CPU store is applied last so it overrides the FSM's Enable/flag update
        if (ctrl_wr) begin
            ctrl_d     = bus.Din[CTRL_WBITS-1:0];
            irq_flag_d = 1'b0;
        end
        if (preset_wr) preset_d = bus.Din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= PRESET_RST;
            count_q    <= 32'd0;
            state_q    <= TC_IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        ctrl_view = ctrl_rd;
`ifdef TIMER_STATE_READ_EN
        ctrl_view[5:4] = state_q;
        ctrl_view[6]   = irq_flag_q;
`endif
    end

    always_comb begin
        case (bus.Addr[3:2])
            TC_CTRL:   bus.Dout = ctrl_view;
            TC_PRESET: bus.Dout = preset_q;
            TC_COUNT:  bus.Dout = count_q;
            default:   bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = ctrl_f.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboarded bench for timer_counter: directed scenarios plus random traffic,
// checked against a timeline model of the countdown (TIMER_STATE_READ_EN aware).
module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam logic [31:0] P_RST = 32'd0;

    logic clk = 1'b0;
    logic reset;
    timer_counter_if bus ();

    timer_counter #(.PRESET_RST(P_RST), .CTRL_WBITS(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dout;
        logic        irq;
        logic [1:0]  a;
        int          seq;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_cur;
    int   seq_no = 0;

    // Reference model: the run is described by its start edge and loaded value;
    // the count and interrupt timing follow from elapsed edges.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    logic        m_run;
    longint      m_edge;
    longint      m_start;
    logic [31:0] m_load;

    function automatic longint run_len();
        return (m_load == 32'd0) ? 64'd1 : {32'd0, m_load};
    endfunction

    task automatic model_reset();
        m_ctrl = 4'd0; m_preset = P_RST; m_count = 32'd0; m_flag = 1'b0;
        m_run = 1'b0; m_start = 0; m_load = 32'd0;
    endtask

    function automatic logic [1:0] model_state();
        longint rel;
        if (!m_run) return 2'd0;
        rel = m_edge - m_start;
        if (rel == 0) return 2'd1;
        if (rel <= run_len()) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        case (a)
            2'd0: begin
                v = {28'd0, m_ctrl};
`ifdef TIMER_STATE_READ_EN
                v[5:4] = model_state();
                v[6]   = m_flag;
`endif
            end
            2'd1: v = m_preset;
            2'd2: v = m_count;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_edge(input logic we, input logic [1:0] a,
                              input logic [31:0] din, input logic rst);
        logic       en;
        logic [1:0] mode;
        longint     rel;
        m_edge++;
        if (rst) begin
            model_reset();
            return;
        end
        en   = m_ctrl[0];
        mode = m_ctrl[2:1];
        if (!m_run) begin
            if (en) begin
                m_run   = 1'b1;
                m_start = m_edge;
            end
        end else begin
            rel = m_edge - m_start;
            if (rel == 1) begin
                m_load  = m_preset;
                m_count = m_preset;
            end else if (rel <= run_len() + 1) begin
                if (!en) m_run = 1'b0;
                else if (rel == run_len() + 1) begin
                    m_count = 32'd0;
                    m_flag  = 1'b1;
                end else m_count = m_load - 32'(rel - 1);
            end else begin
                if (mode == 2'd1) m_flag = 1'b0;
                else m_ctrl[0] = 1'b0;
                m_run = 1'b0;
            end
        end
        if (we && a == 2'd0) begin
            m_ctrl = din[3:0];
            m_flag = 1'b0;
        end
        if (we && a == 2'd1) m_preset = din;
    endtask

    task automatic step(input logic we, input logic [1:0] a,
                        input logic [31:0] din, input logic rst);
        exp_t        e;
        logic [29:0] base;
        base     = ($urandom_range(0, 1) == 0) ? 30'(TC0_BASE >> 2) : 30'(TC1_BASE >> 2);
        reset    = rst;
        bus.WE   = we & ~rst;
        bus.Addr = base | {28'd0, a};
        bus.Din  = din;
        e.dout   = model_read(a);
        e.irq    = m_ctrl[3] & m_flag;
        e.a      = a;
        e.seq    = seq_no++;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(we & ~rst, a, din, rst);
        #1;
        if (rst) $display("txn %0d: reset", e.seq);
        else if (we) $display("txn %0d: write off=%0d data=%h", e.seq, a, din);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) step(1'b0, a, 32'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            checks++;
            if (bus.Dout !== e_cur.dout) begin
                errors++;
                $display("FAIL dout txn %0d off=%0d: got %h want %h", e_cur.seq, e_cur.a, bus.Dout, e_cur.dout);
            end
            checks++;
            if (bus.IRQ !== e_cur.irq) begin
                errors++;
                $display("FAIL irq txn %0d: got %b want %b", e_cur.seq, bus.IRQ, e_cur.irq);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          n;
        int          r;
        m_edge   = 0;
        reset    = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        bus.Din  = 32'd0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;

        // Reset readback and CTRL write mask
        for (int a = 0; a < 4; a++) step(1'b0, 2'(a), 32'd0, 1'b0);
        step(1'b1, TC_CTRL, 32'hFFFF_FFFF, 1'b0);
        idle(2, TC_CTRL);
        step(1'b1, TC_CTRL, 32'h0, 1'b0);

        // One-shot, PRESET=3, then acknowledge with CTRL=0x8
        step(1'b1, TC_PRESET, 32'd3, 1'b0);
        step(1'b1, TC_CTRL, 32'h9, 1'b0);
        idle(7, TC_COUNT);
        idle(2, TC_CTRL);
        step(1'b1, TC_CTRL, 32'h8, 1'b0);
        idle(2, TC_CTRL);

        // Auto-reload, PRESET=2, four periods
        step(1'b1, TC_PRESET, 32'd2, 1'b0);
        step(1'b1, TC_CTRL, 32'hB, 1'b0);
        idle(22, TC_COUNT);
        step(1'b1, TC_CTRL, 32'h0, 1'b0);
        idle(2, TC_CTRL);

        // Masked interrupt
        step(1'b1, TC_CTRL, 32'h1, 1'b0);
        idle(8, TC_CTRL);

        // Disable mid-count at COUNT=5
        step(1'b1, TC_PRESET, 32'd9, 1'b0);
        step(1'b1, TC_CTRL, 32'h1, 1'b0);
        idle(5, TC_COUNT);
        step(1'b1, TC_CTRL, 32'h0, 1'b0);
        idle(4, TC_COUNT);

        // PRESET=0 behaves as 1
        step(1'b1, TC_PRESET, 32'd0, 1'b0);
        step(1'b1, TC_CTRL, 32'h9, 1'b0);
        idle(5, TC_COUNT);

        // PRESET rewrite during CNT
        step(1'b1, TC_PRESET, 32'd5, 1'b0);
        step(1'b1, TC_CTRL, 32'h1, 1'b0);
        idle(3, TC_COUNT);
        step(1'b1, TC_PRESET, 32'd100, 1'b0);
        idle(8, TC_COUNT);

        // CPU CTRL write on the one-shot INT edge keeps Enable
        step(1'b1, TC_PRESET, 32'd1, 1'b0);
        step(1'b1, TC_CTRL, 32'h9, 1'b0);
        idle(3, TC_COUNT);
        step(1'b1, TC_CTRL, 32'h9, 1'b0);
        idle(3, TC_CTRL);

        // Reset while COUNT=7
        step(1'b1, TC_PRESET, 32'd20, 1'b0);
        step(1'b1, TC_CTRL, 32'h9, 1'b0);
        idle(15, TC_COUNT);
        step(1'b0, TC_COUNT, 32'd0, 1'b1);
        for (int a = 0; a < 4; a++) step(1'b0, 2'(a), 32'd0, 1'b0);

        // Random traffic
        for (int it = 0; it < 30; it++) begin
            step(1'b1, TC_PRESET, 32'($urandom_range(0, 6)), 1'b0);
            d    = $urandom();
            d[0] = 1'b1;
            step(1'b1, TC_CTRL, d, 1'b0);
            n = $urandom_range(4, 20);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 6) step(1'b1, TC_CTRL, $urandom(), 1'b0);
                else if (r < 12) step(1'b1, TC_PRESET, 32'($urandom_range(0, 6)), 1'b0);
                else if (r < 14) step(1'b0, TC_COUNT, 32'd0, 1'b1);
                else if (r < 18) step(1'b1, 2'($urandom_range(2, 3)), $urandom(), 1'b0);
                else step(1'b0, 2'($urandom_range(0, 3)), $urandom(), 1'b0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
